// File: rtl/lc3_arb_pkg.sv
// rtl/lc3_arb_pkg.sv - shared types and constants for the LC-3 two-port memory arbiter
package lc3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  // Read data returned to a requester whose access was abandoned by the timeout
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

endpackage

// File: rtl/lc3_arb_rr_pick.sv
// rtl/lc3_arb_rr_pick.sv - two-request round-robin picker
// A tie goes to the port that was not served last; a lone request always wins.
module lc3_arb_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       pick_o
);

  assign valid_o = |req_i;
  assign pick_o  = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - round-robin arbiter sharing one LC-3 memory port between CPU and DMA
// Optional access timeout is enabled with the LC3_ARB_TIMEOUT_EN macro.
module lc3_mem_arbiter
  import lc3_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          req0_en,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_din,
  output logic [DW-1:0] req0_dout,
  output logic          req0_rdy,
  input  logic          req1_en,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_din,
  output logic [DW-1:0] req1_dout,
  output logic          req1_rdy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_rdy,
  output logic [1:0]    grant,
  output logic          err
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       pick_valid, pick;
  logic       busy, tmo, done;
  logic [DW-1:0] rsp_data;

  lc3_arb_rr_pick u_pick (
    .req_i   ({req1_en, req0_en}),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .pick_o  (pick)
  );

  assign busy = (state_q != IDLE);
  assign done = busy && (mem_rdy || tmo);

`ifdef LC3_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // mem_rdy in the same cycle as the limit takes priority over the timeout
  assign tmo = busy && !mem_rdy && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!done) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (!hold && pick_valid) begin
          state_d = pick ? BUSY1 : BUSY0;
        end
      end
      BUSY0: begin
        if (done) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      BUSY1: begin
        if (done) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign grant[PORT_CPU] = (state_q == BUSY0);
  assign grant[PORT_DMA] = (state_q == BUSY1);

  assign rsp_data = tmo ? DW'(TIMEOUT_DATA) : mem_dout;

  // Every memory-side output is forced to zero while no port owns the bus
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant[PORT_CPU]) begin
      mem_en   = 1'b1;
      mem_we   = req0_we;
      mem_addr = req0_addr;
      mem_din  = req0_din;
    end else if (grant[PORT_DMA]) begin
      mem_en   = 1'b1;
      mem_we   = req1_we;
      mem_addr = req1_addr;
      mem_din  = req1_din;
    end
  end

  always_comb begin
    req0_rdy  = 1'b0;
    req0_dout = '0;
    req1_rdy  = 1'b0;
    req1_dout = '0;
    if (grant[PORT_CPU]) begin
      req0_rdy  = mem_rdy || tmo;
      req0_dout = rsp_data;
    end
    if (grant[PORT_DMA]) begin
      req1_rdy  = mem_rdy || tmo;
      req1_dout = rsp_data;
    end
  end

  assign err = tmo;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - self-checking bench for lc3_mem_arbiter with a latency-programmable memory model
module tb_lc3_mem_arbiter;
  import lc3_arb_pkg::*;

`ifdef LC3_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst, hold;
  logic        req0_en, req0_we, req0_rdy;
  logic [15:0] req0_addr, req0_din, req0_dout;
  logic        req1_en, req1_we, req1_rdy;
  logic [15:0] req1_addr, req1_din, req1_dout;
  logic        mem_en, mem_we, mem_rdy;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic [1:0]  grant;
  logic        err;

  lc3_mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_en(req0_en), .req0_we(req0_we), .req0_addr(req0_addr), .req0_din(req0_din),
    .req0_dout(req0_dout), .req0_rdy(req0_rdy),
    .req1_en(req1_en), .req1_we(req1_we), .req1_addr(req1_addr), .req1_din(req1_din),
    .req1_dout(req1_dout), .req1_rdy(req1_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_rdy(mem_rdy), .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: answers mem_lat cycles into an access unless mem_auto is cleared
  logic [15:0] mem_model [logic [15:0]];
  int  mem_lat  = 1;
  bit  mem_auto = 1'b1;
  int  wcnt     = 0;

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 16'hA5A5);
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (mem_rdy) begin
      mem_rdy = 1'b0;
      wcnt    = 0;
    end else if (mem_en && mem_auto) begin
      if (wcnt + 1 >= mem_lat) begin
        if (mem_we) mem_model[mem_addr] = mem_din;
        mem_dout = model_rd(mem_addr);
        mem_rdy  = 1'b1;
      end else begin
        wcnt++;
      end
    end else if (!mem_en) begin
      wcnt = 0;
    end
  end

  // Scoreboard and per-cycle protocol checks
  logic [15:0] q0[$], q1[$];
  logic [1:0]  grant_log[$];
  logic [15:0] e0, e1;
  logic        prev_done  = 1'b0;
  logic [1:0]  prev_grant = 2'b00;
  int          err_cnt    = 0;

  always @(negedge clk) begin
    if (req0_rdy) begin
      if (q0.size() == 0) chk("unexpected_rdy0", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("dout0", req0_dout, e0);
      end
    end
    if (req1_rdy) begin
      if (q1.size() == 0) chk("unexpected_rdy1", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("dout1", req1_dout, e1);
      end
    end
    if (!grant[0]) chk("idle_port0_outputs", {req0_rdy, req0_dout}, 0);
    if (!grant[1]) chk("idle_port1_outputs", {req1_rdy, req1_dout}, 0);
    chk("grant_onehot", (grant == 2'b11), 0);
    chk("mem_en_vs_grant", mem_en, |grant);
    if (grant == 2'b00) chk("idle_mem_bus", {mem_we, mem_addr, mem_din}, 0);
    if (prev_done) chk("turnaround_idle", grant, 2'b00);
    if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
`ifdef LC3_ARB_TIMEOUT_EN
    if (err) err_cnt++;
`else
    chk("err_tied0", err, 0);
`endif
    prev_done  = req0_rdy | req1_rdy;
    prev_grant = grant;
  end

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    int          lat;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  task automatic drive_port(input int p, input logic en, input logic we,
                            input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      req0_en = en; req0_we = we; req0_addr = a; req0_din = d;
    end else begin
      req1_en = en; req1_we = we; req1_addr = a; req1_din = d;
    end
  endtask

  // Call right after a negedge; n counts the sampled cycles up to and including rdy
  task automatic wait_rdy(input int p, output int n);
    n = 1;
    while (!((p == 0) ? req0_rdy : req1_rdy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!((p == 0) ? req0_rdy : req1_rdy)) chk($sformatf("rdy%0d_wait_expired", p), 0, 1);
  endtask

  task automatic do_access(input string tag, input vec_t v);
    int n;
    @(posedge clk); #1;
    mem_lat = v.lat;
    drive_port(v.port, 1'b1, v.we, v.addr, v.din);
    if (v.port == 0) q0.push_back(v.exp_dout); else q1.push_back(v.exp_dout);
    @(negedge clk);
    chk({tag, "_req_to_grant"}, grant, 2'b00);
    @(negedge clk);
    chk({tag, "_grant"}, grant, (v.port == 0) ? 2'b01 : 2'b10);
    chk({tag, "_mem_addr"}, mem_addr, v.addr);
    chk({tag, "_mem_we"}, mem_we, v.we);
    chk({tag, "_mem_din"}, mem_din, v.din);
    wait_rdy(v.port, n);
    chk({tag, "_busy_cycles"}, n, v.lat);
    @(posedge clk); #1;
    drive_port(v.port, 1'b0, v.we, v.addr, v.din);
    @(negedge clk);
    chk({tag, "_single_pulse"}, (v.port == 0) ? req0_rdy : req1_rdy, 0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n, done0, done1;
    logic r0, r1;
    logic [1:0] exp_order [4];
    vec_t v;

    rst = 1'b1; hold = 1'b0; mem_rdy = 1'b0; mem_dout = 16'h0;
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    mem_model[16'h3000] = 16'h1234;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;

    vecs[0] = '{0, 1'b0, 16'h3000, 16'h0000, 3, 16'h1234};
    vecs[1] = '{1, 1'b1, 16'hFE10, 16'hCAFE, 1, 16'hCAFE};
    vecs[2] = '{0, 1'b1, 16'h4000, 16'h55AA, 2, 16'h55AA};
    vecs[3] = '{1, 1'b0, 16'hFE10, 16'h0000, 2, 16'hCAFE};
    vecs[4] = '{0, 1'b0, 16'h4000, 16'h1111, 1, 16'h55AA};
    vecs[5] = '{1, 1'b0, 16'h0000, 16'h0000, 4, 16'hA5A5};
    vecs[6] = '{0, 1'b1, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF};
    vecs[7] = '{1, 1'b0, 16'hFFFF, 16'h0000, 2, 16'hFFFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {grant, mem_en, mem_we, mem_addr, mem_din, req0_rdy, req1_rdy, err}, 0);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) do_access($sformatf("vec%0d", i), vecs[i]);

    // Both ports requesting continuously right after reset: 0,1,0,1
    reset_dut();
    grant_log.delete();
    mem_lat = 2;
    drive_port(0, 1'b1, 1'b0, 16'h1000, 16'h0);
    drive_port(1, 1'b1, 1'b0, 16'h2000, 16'h0);
    q0.push_back(model_rd(16'h1000));
    q1.push_back(model_rd(16'h2000));
    done0 = 0; done1 = 0;
    for (int c = 0; c < 80 && (done0 < 2 || done1 < 2); c++) begin
      @(negedge clk);
      r0 = req0_rdy; r1 = req1_rdy;
      @(posedge clk); #1;
      if (r0) begin
        done0++;
        if (done0 < 2) begin
          req0_addr = req0_addr + 16'h1;
          q0.push_back(model_rd(req0_addr));
        end else req0_en = 1'b0;
      end
      if (r1) begin
        done1++;
        if (done1 < 2) begin
          req1_addr = req1_addr + 16'h1;
          q1.push_back(model_rd(req1_addr));
        end else req1_en = 1'b0;
      end
    end
    chk("tie_done0", done0, 2);
    chk("tie_done1", done1, 2);
    chk("tie_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("tie_order%0d", i), grant_log[i], exp_order[i]);

    // hold blocks new grants but not an access in flight
    @(posedge clk); #1;
    hold = 1'b1;
    mem_lat = 4;
    drive_port(1, 1'b1, 1'b1, 16'hFE00, 16'hBEEF);
    q1.push_back(16'hBEEF);
    repeat (5) begin
      @(negedge clk);
      chk("hold_no_mem_en", mem_en, 0);
    end
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_idle", grant, 2'b00);
    @(negedge clk);
    chk("hold_write_grant", grant, 2'b10);
    chk("hold_write_we", mem_we, 1);
    chk("hold_write_din", mem_din, 16'hBEEF);
    chk("hold_write_addr", mem_addr, 16'hFE00);
    @(posedge clk); #1;
    hold = 1'b1;
    drive_port(0, 1'b1, 1'b0, 16'hFE00, 16'h0);
    q0.push_back(16'hBEEF);
    @(negedge clk);
    wait_rdy(1, n);
    @(posedge clk); #1;
    req1_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("hold_blocks_next", grant, 2'b00);
    end
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_readback_grant", grant, 2'b01);
    wait_rdy(0, n);
    @(posedge clk); #1;
    req0_en = 1'b0;

    // Reset in the middle of BUSY0 after port 0 was served last
    v = '{0, 1'b0, 16'h0100, 16'h0000, 1, model_rd(16'h0100)};
    do_access("pre_rst", v);
    @(posedge clk); #1;
    mem_auto = 1'b0;
    drive_port(0, 1'b1, 1'b0, 16'h0200, 16'h0);
    q0.push_back(model_rd(16'h0200));
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy0_grant", grant, 2'b01);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_mem_en", mem_en, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    mem_auto = 1'b1;
    mem_lat = 1;
    drive_port(1, 1'b1, 1'b0, 16'h0300, 16'h0);
    q0.push_back(model_rd(16'h0200));
    q1.push_back(model_rd(16'h0300));
    @(negedge clk);
    chk("post_rst_mem_en", mem_en, 0);
    chk("post_rst_grant", grant, 2'b00);
    chk("post_rst_rdy0", req0_rdy, 0);
    @(negedge clk);
    chk("post_rst_tie_grant", grant, 2'b01);
    wait_rdy(0, n);
    @(posedge clk); #1;
    req0_en = 1'b0;
    @(negedge clk);
    wait_rdy(1, n);
    @(posedge clk); #1;
    req1_en = 1'b0;

    // Requester drops en mid-access; the access still completes
    mem_lat = 3;
    drive_port(1, 1'b1, 1'b0, 16'h0400, 16'h0);
    q1.push_back(model_rd(16'h0400));
    @(negedge clk);
    @(negedge clk);
    chk("drop_en_grant", grant, 2'b10);
    @(posedge clk); #1;
    req1_en = 1'b0;
    @(negedge clk);
    wait_rdy(1, n);
    chk("drop_en_rdy", req1_rdy, 1);

`ifdef LC3_ARB_TIMEOUT_EN
    // Memory never answers port 0; port 1 waits behind it
    reset_dut();
    mem_auto = 1'b0;
    mem_lat = 1;
    drive_port(0, 1'b1, 1'b0, 16'h0500, 16'h0);
    drive_port(1, 1'b1, 1'b0, 16'h0600, 16'h0);
    q0.push_back(TIMEOUT_DATA);
    q1.push_back(model_rd(16'h0600));
    @(negedge clk);
    @(negedge clk);
    chk("tmo_grant0", grant, 2'b01);
    wait_rdy(0, n);
    chk("tmo_busy_cycles", n, TMO + 1);
    chk("tmo_err", err, 1);
    mem_auto = 1'b1;
    @(posedge clk); #1;
    req0_en = 1'b0;
    @(negedge clk);
    chk("tmo_err_pulse", err, 0);
    @(negedge clk);
    chk("tmo_then_grant1", grant, 2'b10);
    wait_rdy(1, n);
    @(posedge clk); #1;
    req1_en = 1'b0;
    @(negedge clk);
    chk("tmo_err_count", err_cnt, 1);

    // mem_rdy in the timeout cycle wins
    v = '{0, 1'b0, 16'h0700, 16'h0000, TMO + 1, model_rd(16'h0700)};
    do_access("tmo_race", v);
    chk("tmo_race_err_count", err_cnt, 1);
`endif

    repeat (3) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
